// File: rtl/matrix_frame_sequencer.sv
// Frame-buffer read sequencer feeding a 3x3 matrix generator with vsync/href/gray timing.
// Optional MATRIX_FLUSH_LINE_EN adds a dummy line after the last image line to drain the line buffer.
module matrix_frame_sequencer #(
    parameter logic [10:0] IMG_HDISP  = 11'd640,
    parameter logic [10:0] IMG_VDISP  = 11'd480,
    parameter int unsigned HBLANK_CYC = 16,
    parameter int unsigned VS_LEAD    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_rd_en,
    output logic [19:0] mem_addr,
    input  logic [7:0]  mem_rd_data,
    output logic        gen_vsync,
    output logic        gen_href,
    output logic [7:0]  gen_gray,
    output logic        busy,
    output logic        frame_done,
    output logic [10:0] line_idx
);

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned LIDX_W = 11;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(32'(IMG_HDISP) * 32'(IMG_VDISP) - 32'd1);
    localparam logic [CNT_W-1:0]  LEAD_LAST  = CNT_W'(VS_LEAD - 1);
    localparam logic [CNT_W-1:0]  LINE_LAST  = CNT_W'(32'(IMG_HDISP) - 32'd1);
    localparam logic [CNT_W-1:0]  HB_LAST    = CNT_W'(HBLANK_CYC - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(32'(IMG_HDISP) + HBLANK_CYC - 32'd1);
    localparam logic [CNT_W-1:0]  TAIL_LAST  = CNT_W'(3);
    localparam logic [LIDX_W-1:0] LIDX_LAST  = LIDX_W'(32'(IMG_VDISP) - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_LEAD,
        S_LINE,
        S_HBLANK,
        S_FLUSH,
        S_VS_TAIL,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               flush_en;
    logic               flush_d;

    // State, counters and registered outputs; outputs are set from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            gen_vsync  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_idx   <= '0;
            flush_en   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_VS_LEAD;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        gen_vsync <= 1'b1;
                        mem_addr  <= '0;
                        line_idx  <= '0;
                    end
                end
                S_VS_LEAD: begin
                    if (cnt == LEAD_LAST) begin
                        state     <= S_LINE;
                        cnt       <= '0;
                        mem_rd_en <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_LINE: begin
                    if (mem_addr != LAST_ADDR) begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    if (cnt == LINE_LAST) begin
                        state     <= S_HBLANK;
                        cnt       <= '0;
                        mem_rd_en <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HBLANK: begin
                    if (cnt == HB_LAST) begin
                        cnt <= '0;
                        if (line_idx < LIDX_LAST) begin
                            state     <= S_LINE;
                            line_idx  <= line_idx + LIDX_W'(1);
                            mem_rd_en <= 1'b1;
                        end else begin
`ifdef MATRIX_FLUSH_LINE_EN
                            state    <= S_FLUSH;
                            flush_en <= 1'b1;
`else
                            state    <= S_VS_TAIL;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Dummy line of IMG_HDISP strobes followed by a normal blanking gap.
                S_FLUSH: begin
                    if (cnt == LINE_LAST) begin
                        flush_en <= 1'b0;
                    end
                    if (cnt == FLUSH_LAST) begin
                        state <= S_VS_TAIL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_VS_TAIL: begin
                    if (cnt == TAIL_LAST) begin
                        state      <= S_DONE;
                        cnt        <= '0;
                        gen_vsync  <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // href tracks the read strobe with one cycle of memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_href <= 1'b0;
            flush_d  <= 1'b0;
        end else begin
            gen_href <= mem_rd_en | flush_en;
            flush_d  <= flush_en;
        end
    end

    assign gen_gray = (gen_href && !flush_d) ? mem_rd_data : 8'h00;

endmodule
